axis_dual_input_unit: RTL and testbench
=======================================

# axis_dual_input_unit

Two-input, one-output AXI-Stream processing unit that merges a data stream and an auxiliary stream into one output stream. A compile-time MODE selects one of three functions: combiner (interleave fixed-size bursts from both inputs), filter (drop or keep data words according to a flag stream) or shifter (shift each data word by a per-word amount). It sits between stream producers and consumers in the compression datapath and has a one-entry registered output stage.

## Interface
- MODE, 0: 0 = combiner, 1 = filter, 2 = shifter.
- DATA_WIDTH, 39: width of input_0 and output data.
- AUX_WIDTH, 6: width of input_1 data (second data, flag or shift amount).
- FROM_PORT_ZERO, 16: combiner words taken from input_0 per cycle of the pattern; must be ≥1.
- FROM_PORT_ONE, 7: combiner words taken from input_1 per cycle of the pattern; must be ≥1.
- ELIMINATE_ON_UP, 1: filter; 1 drops the word when the flag is 1, 0 drops it when the flag is 0.
- LEFT, 1: shifter; 1 shifts left, 0 shifts right.
- ARITHMETIC, 0: shifter; a right shift is sign-filling when 1.
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- input_0_valid / input_0_ready  in/out  1  data stream handshake.
- input_0_data  in  DATA_WIDTH  data word.
- input_1_valid / input_1_ready  in/out  1  auxiliary stream handshake.
- input_1_data  in  AUX_WIDTH  second data word, flag or shift amount.
- output_valid / output_ready  out/in  1  output handshake.
- output_data  out  DATA_WIDTH  result word.

## Operation
- Transfer rule: a beat transfers on a port when valid and ready are both high at a rising edge.
- Output slot rule: "slot free" means the output register is empty, or it is full and output_ready is high in the same cycle.
- Combiner:
  - Phase counter starts in phase P0 with count 0.
  - In P0, input_0_ready equals slot free and input_1_ready is 0.
  - In P1, input_1_ready equals slot free and input_0_ready is 0.
  - Each accepted word is loaded into the slot; input_1_data is zero-extended, or truncated, to DATA_WIDTH.
  - After FROM_PORT_ZERO accepts in P0, the block moves to P1. After FROM_PORT_ONE accepts in P1, it returns to P0. The count wraps to 0 at each switch.
- Filter and shifter (joined consumption):
  - input_0_ready and input_1_ready are both equal to (input_0_valid & input_1_valid & slot free).
  - Both streams are therefore always consumed together. A lone valid on one input is never consumed.
- Filter:
  - The flag is input_1_data[0]; the upper bits are ignored.
  - Drop condition: the flag equals ELIMINATE_ON_UP.
  - A dropped word is consumed and never loaded into the slot. A kept word loads input_0_data unchanged.
- Shifter:
  - The shift amount is input_1_data, unsigned.
  - LEFT=1: the result is data << amount, zero-filled.
  - LEFT=0, ARITHMETIC=0: the result is a logical right shift.
  - LEFT=0, ARITHMETIC=1: the result is a right shift that fills with the MSB.
  - If amount ≥ DATA_WIDTH, the result is all zeros, or all copies of the MSB for an arithmetic right shift.

## Timing
- Reset: while rst=0, output_valid=0, the slot is empty, output_data=0 and the combiner is in P0 with count 0. Readies follow the rules above; both are 0 in joined modes because the slot rule gates them, and they are never high during reset.
- Latency: one cycle from input acceptance to output_valid.
- Throughput: one word per cycle when output_ready is held high.
- Output stability: output_data and output_valid stay stable while output_valid=1 and output_ready=0.
- No combinational path from input_*_valid to output_valid. Ready depends combinationally on output_ready.
- Simultaneous drain and load: the slot is replaced with no bubble.
- Reset mid-operation: the slot contents and combiner phase are discarded immediately.

## Structure
- Shared package holds:
  - the MODE enumeration constants (COMBINE, FILTER, SHIFT);
  - the combiner phase typedef (P0, P1).
- One natural sub-module is axis_output_slot: a one-entry register with valid, ready and data, plus a "free" output.
- Each mode is a generate branch feeding that slot.

## Test plan
- Combiner, 16/7, both inputs always valid with incrementing data, output always ready:
  - the output sequence is input_0 words 0..15, then input_1 words 0..6 zero-extended, then input_0 word 16 onward;
  - no idle cycles.
- Combiner backpressure: hold output_ready=0 for 5 cycles mid-burst.
  - The output holds one word stable with both readies 0.
  - After release, the sequence continues without loss or duplication.
  - The phase count is preserved.
- Filter, ELIMINATE_ON_UP=1, flags 0,1,1,0 with data A,B,C,D:
  - the output is A then D;
  - all four pairs are consumed.
- Filter with input_1_valid=0 and input_0_valid=1:
  - both readies stay 0 and there is no output.
  - Raising input_1_valid gives acceptance next edge and output one cycle later.
- Shifter, LEFT=1:
  - data 0x1, amount 5 gives 0x20;
  - amount 39 gives 0.
- Shifter, LEFT=0, ARITHMETIC=1, data with MSB set (0x4000000000), amount 4:
  - the result has the top 5 bits set (0x7C00000000).
- Reset asserted mid-stream:
  - output_valid drops to 0 immediately;
  - after release, the combiner restarts in P0 with count 0.

Source files
------------

// File: rtl/axis_dual_input_unit_pkg.sv
// Shared definitions for the dual-input AXI-Stream unit: the mode
// encoding, the combiner phase type and a small elaboration helper.
package axis_dual_input_unit_pkg;

    // Function selected by the MODE parameter of axis_dual_input_unit.
    typedef enum logic [1:0] {
        COMBINE = 2'd0,
        FILTER  = 2'd1,
        SHIFT   = 2'd2
    } mode_e;

    // Combiner phase: P0 takes words from input_0, P1 from input_1.
    typedef enum logic [0:0] {
        P0 = 1'b0,
        P1 = 1'b1
    } comb_phase_e;

    // Larger of two elaboration-time integers (used to size counters).
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axis_dual_input_unit_output_slot.sv
// One-entry registered output stage. A word may be loaded whenever the
// slot is free, i.e. empty or being drained in the same cycle, so a
// continuous stream passes with no bubbles. The slot reports itself as
// not free while reset is asserted so no producer sees a ready then.
module axis_output_slot
    import axis_dual_input_unit_pkg::*;
#(
    parameter int WIDTH = 39
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             output_ready,
    output logic             output_valid,
    output logic [WIDTH-1:0] output_data,
    output logic             free
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Slot can take a word when empty or when its current word leaves now.
    always_comb begin
        free = rst & (~valid_q | output_ready);
    end

    // Next slot state: load has priority, otherwise drain on output_ready.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_valid && free) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (output_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers; reset empties the slot and clears the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign output_valid = valid_q;
    assign output_data  = data_q;

endmodule

// File: rtl/axis_dual_input_unit.sv
// Two-input, one-output AXI-Stream unit. MODE selects a combiner
// (fixed-size bursts alternately from both inputs), a filter (drop or keep
// input_0 words by a flag on input_1) or a shifter (shift input_0 words by
// the amount on input_1). Every mode feeds one registered output slot, so
// output_valid never depends combinationally on the input valids.
module axis_dual_input_unit
    import axis_dual_input_unit_pkg::*;
#(
    parameter int MODE            = 0,
    parameter int DATA_WIDTH      = 39,
    parameter int AUX_WIDTH       = 6,
    parameter int FROM_PORT_ZERO  = 16,
    parameter int FROM_PORT_ONE   = 7,
    parameter int ELIMINATE_ON_UP = 1,
    parameter int LEFT            = 1,
    parameter int ARITHMETIC      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_0_valid,
    output logic                  input_0_ready,
    input  logic [DATA_WIDTH-1:0] input_0_data,
    input  logic                  input_1_valid,
    output logic                  input_1_ready,
    input  logic [AUX_WIDTH-1:0]  input_1_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [DATA_WIDTH-1:0] output_data
);

    logic                  slot_free_s;
    logic                  load_valid_s;
    logic [DATA_WIDTH-1:0] load_data_s;

    if (MODE == int'(COMBINE)) begin : g_combine
        localparam int CNT_W = $clog2(max_int(FROM_PORT_ZERO, FROM_PORT_ONE) + 1);
        localparam int EXT_W = (AUX_WIDTH < DATA_WIDTH) ? AUX_WIDTH : DATA_WIDTH;

        comb_phase_e           phase_q;
        comb_phase_e           phase_d;
        logic [CNT_W-1:0]      count_q;
        logic [CNT_W-1:0]      count_d;
        logic                  acc0_s;
        logic                  acc1_s;
        logic [DATA_WIDTH-1:0] aux_ext_s;

        // input_1 word zero-extended (or truncated) to the output width.
        always_comb begin
            aux_ext_s              = {DATA_WIDTH{1'b0}};
            aux_ext_s[EXT_W-1:0]   = input_1_data[EXT_W-1:0];
        end

        // Only the port owning the current phase is offered the free slot.
        always_comb begin
            input_0_ready = (phase_q == P0) ? slot_free_s : 1'b0;
            input_1_ready = (phase_q == P1) ? slot_free_s : 1'b0;
            acc0_s        = input_0_valid & input_0_ready;
            acc1_s        = input_1_valid & input_1_ready;
            load_valid_s  = acc0_s | acc1_s;
            if (acc0_s) begin
                load_data_s = input_0_data;
            end else begin
                load_data_s = aux_ext_s;
            end
        end

        // Burst counter: switch phase after the configured number of accepts.
        always_comb begin
            phase_d = phase_q;
            count_d = count_q;
            case (phase_q)
                P0: begin
                    if (acc0_s) begin
                        if (count_q == CNT_W'(FROM_PORT_ZERO - 1)) begin
                            phase_d = P1;
                            count_d = {CNT_W{1'b0}};
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                P1: begin
                    if (acc1_s) begin
                        if (count_q == CNT_W'(FROM_PORT_ONE - 1)) begin
                            phase_d = P0;
                            count_d = {CNT_W{1'b0}};
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                default: begin
                    phase_d = P0;
                    count_d = {CNT_W{1'b0}};
                end
            endcase
        end

        // Phase and count registers; reset restarts in P0 with count 0.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                phase_q <= P0;
                count_q <= {CNT_W{1'b0}};
            end else begin
                phase_q <= phase_d;
                count_q <= count_d;
            end
        end

    end else if (MODE == int'(FILTER)) begin : g_filter
        localparam logic ELIM_FLAG = (ELIMINATE_ON_UP != 0) ? 1'b1 : 1'b0;

        logic joined_s;
        logic drop_s;
        logic unused_aux_s;

        // Only bit 0 of input_1 is the flag; the rest is deliberately ignored.
        assign unused_aux_s = ^input_1_data;

        // Pairs are consumed together; dropped words never reach the slot.
        always_comb begin
            joined_s      = input_0_valid & input_1_valid & slot_free_s;
            drop_s        = (input_1_data[0] == ELIM_FLAG);
            input_0_ready = joined_s;
            input_1_ready = joined_s;
            load_valid_s  = joined_s & ~drop_s;
            load_data_s   = input_0_data;
        end

    end else if (MODE == int'(SHIFT)) begin : g_shift
        logic                  joined_s;
        logic                  fill_s;
        logic [DATA_WIDTH-1:0] shifted_s;

        // Shift result; out-of-range amounts saturate to the fill value.
        always_comb begin
            fill_s = (LEFT == 0) && (ARITHMETIC != 0) && input_0_data[DATA_WIDTH-1];
            if (int'(input_1_data) >= DATA_WIDTH) begin
                shifted_s = {DATA_WIDTH{fill_s}};
            end else if (LEFT != 0) begin
                shifted_s = input_0_data << input_1_data;
            end else if (ARITHMETIC != 0) begin
                shifted_s = $unsigned($signed(input_0_data) >>> input_1_data);
            end else begin
                shifted_s = input_0_data >> input_1_data;
            end
        end

        // Data word and amount are consumed together into the slot.
        always_comb begin
            joined_s      = input_0_valid & input_1_valid & slot_free_s;
            input_0_ready = joined_s;
            input_1_ready = joined_s;
            load_valid_s  = joined_s;
            load_data_s   = shifted_s;
        end

    end else begin : g_idle
        logic unused_inputs_s;

        // An unsupported MODE accepts nothing and never produces output.
        assign unused_inputs_s = ^{input_0_valid, input_0_data, input_1_valid, input_1_data};

        // Tie every producer-facing control low.
        always_comb begin
            input_0_ready = 1'b0;
            input_1_ready = 1'b0;
            load_valid_s  = 1'b0;
            load_data_s   = {DATA_WIDTH{1'b0}};
        end
    end

    axis_output_slot #(
        .WIDTH (DATA_WIDTH)
    ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid_s),
        .load_data    (load_data_s),
        .output_ready (output_ready),
        .output_valid (output_valid),
        .output_data  (output_data),
        .free         (slot_free_s)
    );

endmodule

// File: tb/tb_axis_dual_input_unit.sv
// Directed bench for axis_dual_input_unit. Four instances cover the
// combiner, the filter and the two shifter directions; each scenario task
// drives its instance and checks results against hand-computed values.
module tb_axis_dual_input_unit;

    logic clk;
    logic rst;

    // combiner instance signals
    logic        c_in0_valid, c_in0_ready, c_in1_valid, c_in1_ready;
    logic [38:0] c_in0_data;
    logic [5:0]  c_in1_data;
    logic        c_out_valid, c_out_ready;
    logic [38:0] c_out_data;
    // filter instance signals
    logic        f_in0_valid, f_in0_ready, f_in1_valid, f_in1_ready;
    logic [38:0] f_in0_data;
    logic [5:0]  f_in1_data;
    logic        f_out_valid, f_out_ready;
    logic [38:0] f_out_data;
    // left shifter instance signals
    logic        l_in0_valid, l_in0_ready, l_in1_valid, l_in1_ready;
    logic [38:0] l_in0_data;
    logic [5:0]  l_in1_data;
    logic        l_out_valid, l_out_ready;
    logic [38:0] l_out_data;
    // arithmetic right shifter instance signals
    logic        r_in0_valid, r_in0_ready, r_in1_valid, r_in1_ready;
    logic [38:0] r_in0_data;
    logic [5:0]  r_in1_data;
    logic        r_out_valid, r_out_ready;
    logic [38:0] r_out_data;

    int errors;
    int checks;
    int i0;
    int i1;

    axis_dual_input_unit #(.MODE(0)) u_comb (
        .clk(clk), .rst(rst),
        .input_0_valid(c_in0_valid), .input_0_ready(c_in0_ready), .input_0_data(c_in0_data),
        .input_1_valid(c_in1_valid), .input_1_ready(c_in1_ready), .input_1_data(c_in1_data),
        .output_valid(c_out_valid), .output_ready(c_out_ready), .output_data(c_out_data));

    axis_dual_input_unit #(.MODE(1), .ELIMINATE_ON_UP(1)) u_filt (
        .clk(clk), .rst(rst),
        .input_0_valid(f_in0_valid), .input_0_ready(f_in0_ready), .input_0_data(f_in0_data),
        .input_1_valid(f_in1_valid), .input_1_ready(f_in1_ready), .input_1_data(f_in1_data),
        .output_valid(f_out_valid), .output_ready(f_out_ready), .output_data(f_out_data));

    axis_dual_input_unit #(.MODE(2), .LEFT(1), .ARITHMETIC(0)) u_shl (
        .clk(clk), .rst(rst),
        .input_0_valid(l_in0_valid), .input_0_ready(l_in0_ready), .input_0_data(l_in0_data),
        .input_1_valid(l_in1_valid), .input_1_ready(l_in1_ready), .input_1_data(l_in1_data),
        .output_valid(l_out_valid), .output_ready(l_out_ready), .output_data(l_out_data));

    axis_dual_input_unit #(.MODE(2), .LEFT(0), .ARITHMETIC(1)) u_shr (
        .clk(clk), .rst(rst),
        .input_0_valid(r_in0_valid), .input_0_ready(r_in0_ready), .input_0_data(r_in0_data),
        .input_1_valid(r_in1_valid), .input_1_ready(r_in1_ready), .input_1_data(r_in1_data),
        .output_valid(r_out_valid), .output_ready(r_out_ready), .output_data(r_out_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected combiner output for the n-th transfer of a 16/7 pattern.
    function automatic logic [38:0] comb_exp(input int n);
        int r;
        int c;
        r = n % 23;
        c = n / 23;
        if (r < 16) return 39'(c * 16 + r);
        else        return 39'(c * 7 + (r - 16));
    endfunction

    // True when the n-th combiner transfer comes from input_0.
    function automatic logic comb_exp_p0(input int n);
        return ((n % 23) < 16) ? 1'b1 : 1'b0;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        c_in0_valid = 1'b1; c_in1_valid = 1'b1; c_out_ready = 1'b1;
        c_in0_data = 39'd0; c_in1_data = 6'd0;
        f_in0_valid = 1'b0; f_in1_valid = 1'b0; f_out_ready = 1'b1;
        f_in0_data = 39'd0; f_in1_data = 6'd0;
        l_in0_valid = 1'b0; l_in1_valid = 1'b0; l_out_ready = 1'b1;
        l_in0_data = 39'd0; l_in1_data = 6'd0;
        r_in0_valid = 1'b0; r_in1_valid = 1'b0; r_out_ready = 1'b1;
        r_in0_data = 39'd0; r_in1_data = 6'd0;
        i0 = 0; i1 = 0;
        for (int k = 0; k < 3; k++) begin
            #3;
            checks++;
            if ({c_out_valid, f_out_valid, l_out_valid, r_out_valid} !== 4'b0000 ||
                c_out_data !== 39'd0 || f_out_data !== 39'd0 ||
                l_out_data !== 39'd0 || r_out_data !== 39'd0) begin
                errors++;
                $display("FAIL reset_outputs: got valids=%b data c=%h f=%h l=%h r=%h, want 0000 and all 0",
                         {c_out_valid, f_out_valid, l_out_valid, r_out_valid},
                         c_out_data, f_out_data, l_out_data, r_out_data);
            end
            checks++;
            if ({c_in0_ready, c_in1_ready, f_in0_ready, f_in1_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_readies: got c=%b%b f=%b%b, want 00 00",
                         c_in0_ready, c_in1_ready, f_in0_ready, f_in1_ready);
            end
            @(posedge clk);
        end
        #1;
        rst = 1'b1;
    endtask

    task automatic test_combine_stream(input int first, input int last);
        logic acc0;
        logic acc1;
        for (int n = first; n <= last; n++) begin
            #1;
            checks++;
            if (c_in0_ready !== comb_exp_p0(n) || c_in1_ready !== ~comb_exp_p0(n)) begin
                errors++;
                $display("FAIL comb_ready n=%0d: got in0_ready=%b in1_ready=%b, want %b %b",
                         n, c_in0_ready, c_in1_ready, comb_exp_p0(n), ~comb_exp_p0(n));
            end
            acc0 = c_in0_valid & c_in0_ready;
            acc1 = c_in1_valid & c_in1_ready;
            @(posedge clk);
            #1;
            if (acc0) begin i0++; c_in0_data = 39'(i0); end
            if (acc1) begin i1++; c_in1_data = 6'(i1); end
            checks++;
            if (c_out_valid !== 1'b1 || c_out_data !== comb_exp(n)) begin
                errors++;
                $display("FAIL comb_output n=%0d: got valid=%b data=%h, want valid=1 data=%h",
                         n, c_out_valid, c_out_data, comb_exp(n));
            end
        end
    endtask

    task automatic test_combine_backpressure();
        c_out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            checks++;
            if (c_in0_ready !== 1'b0 || c_in1_ready !== 1'b0) begin
                errors++;
                $display("FAIL comb_stall_ready s=%0d: got %b %b, want 0 0", s, c_in0_ready, c_in1_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (c_out_valid !== 1'b1 || c_out_data !== comb_exp(32)) begin
                errors++;
                $display("FAIL comb_stall_hold s=%0d: got valid=%b data=%h, want valid=1 data=%h",
                         s, c_out_valid, c_out_data, comb_exp(32));
            end
        end
        c_out_ready = 1'b1;
        test_combine_stream(33, 40);
    endtask

    task automatic test_reset_midstream();
        rst = 1'b0;
        #1;
        checks++;
        if (c_out_valid !== 1'b0 || c_out_data !== 39'd0 || c_in0_ready !== 1'b0 || c_in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got valid=%b data=%h readies=%b%b, want valid=0 data=0 readies=00",
                     c_out_valid, c_out_data, c_in0_ready, c_in1_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        i0 = 0; i1 = 0;
        c_in0_data = 39'd0; c_in1_data = 6'd0;
        test_combine_stream(0, 24);
    endtask

    task automatic test_filter_drop();
        logic [38:0] fd [4];
        logic [5:0]  fl [4];
        logic        fk [4];
        int          consumed;
        fd = '{39'h00_0000_0A0A, 39'h00_000B_0B0B, 39'h0C_0C0C_0C0C, 39'h7D_0D0D_0D0D};
        fl = '{6'h2A, 6'h01, 6'h3F, 6'h3E};
        fk = '{1'b1, 1'b0, 1'b0, 1'b1};
        consumed = 0;
        f_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            f_in0_valid = 1'b1; f_in1_valid = 1'b1;
            f_in0_data = fd[k]; f_in1_data = fl[k];
            #1;
            checks++;
            if (f_in0_ready !== 1'b1 || f_in1_ready !== 1'b1) begin
                errors++;
                $display("FAIL filt_ready k=%0d: got %b %b, want 1 1", k, f_in0_ready, f_in1_ready);
            end
            if (f_in0_ready && f_in1_ready) consumed++;
            @(posedge clk);
            #1;
            checks++;
            if (f_out_valid !== fk[k] || (fk[k] && f_out_data !== fd[k])) begin
                errors++;
                $display("FAIL filt_output k=%0d: got valid=%b data=%h, want valid=%b data=%h",
                         k, f_out_valid, f_out_data, fk[k], fd[k]);
            end
        end
        f_in0_valid = 1'b0; f_in1_valid = 1'b0;
        checks++;
        if (consumed != 4) begin
            errors++;
            $display("FAIL filt_consumed: got %0d pairs, want 4", consumed);
        end
        @(posedge clk);
        #1;
        checks++;
        if (f_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL filt_drain: got valid=%b, want 0", f_out_valid);
        end
    endtask

    task automatic test_filter_lone_valid();
        f_in0_valid = 1'b1; f_in0_data = 39'h00_0123_4567;
        f_in1_valid = 1'b0; f_in1_data = 6'h00;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (f_in0_ready !== 1'b0 || f_in1_ready !== 1'b0) begin
                errors++;
                $display("FAIL filt_lone_ready k=%0d: got %b %b, want 0 0", k, f_in0_ready, f_in1_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (f_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL filt_lone_output k=%0d: got valid=%b, want 0", k, f_out_valid);
            end
        end
        f_in1_valid = 1'b1;
        #1;
        checks++;
        if (f_in0_ready !== 1'b1 || f_in1_ready !== 1'b1) begin
            errors++;
            $display("FAIL filt_join_ready: got %b %b, want 1 1", f_in0_ready, f_in1_ready);
        end
        @(posedge clk);
        #1;
        f_in0_valid = 1'b0; f_in1_valid = 1'b0;
        checks++;
        if (f_out_valid !== 1'b1 || f_out_data !== 39'h00_0123_4567) begin
            errors++;
            $display("FAIL filt_join_output: got valid=%b data=%h, want valid=1 data=0001234567",
                     f_out_valid, f_out_data);
        end
    endtask

    task automatic test_shift_left();
        logic [38:0] sd [6];
        logic [5:0]  sa [6];
        logic [38:0] se [6];
        sd = '{39'h00_0000_0001, 39'h00_0000_0001, 39'h00_0000_0001,
               39'h40_0000_0001, 39'h7F_FFFF_FFFF, 39'h00_0000_0003};
        sa = '{6'd5, 6'd39, 6'd38, 6'd1, 6'd63, 6'd0};
        se = '{39'h00_0000_0020, 39'h00_0000_0000, 39'h40_0000_0000,
               39'h00_0000_0002, 39'h00_0000_0000, 39'h00_0000_0003};
        for (int k = 0; k < 6; k++) begin
            l_in0_valid = 1'b1; l_in1_valid = 1'b1;
            l_in0_data = sd[k]; l_in1_data = sa[k];
            @(posedge clk);
            #1;
            checks++;
            if (l_out_valid !== 1'b1 || l_out_data !== se[k]) begin
                errors++;
                $display("FAIL shl k=%0d: got valid=%b data=%h, want valid=1 data=%h",
                         k, l_out_valid, l_out_data, se[k]);
            end
        end
        l_in0_valid = 1'b0; l_in1_valid = 1'b0;
    endtask

    task automatic test_shift_arith_right();
        logic [38:0] sd [6];
        logic [5:0]  sa [6];
        logic [38:0] se [6];
        sd = '{39'h40_0000_0000, 39'h40_0000_0000, 39'h40_0000_0000,
               39'h20_0000_0000, 39'h20_0000_0000, 39'h55_0000_00AA};
        sa = '{6'd4, 6'd39, 6'd38, 6'd4, 6'd63, 6'd0};
        se = '{39'h7C_0000_0000, 39'h7F_FFFF_FFFF, 39'h7F_FFFF_FFFF,
               39'h02_0000_0000, 39'h00_0000_0000, 39'h55_0000_00AA};
        for (int k = 0; k < 6; k++) begin
            r_in0_valid = 1'b1; r_in1_valid = 1'b1;
            r_in0_data = sd[k]; r_in1_data = sa[k];
            @(posedge clk);
            #1;
            checks++;
            if (r_out_valid !== 1'b1 || r_out_data !== se[k]) begin
                errors++;
                $display("FAIL shr_arith k=%0d: got valid=%b data=%h, want valid=1 data=%h",
                         k, r_out_valid, r_out_data, se[k]);
            end
        end
        r_in0_valid = 1'b0; r_in1_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        // stall the left shifter with a word held, then release with a new pair pending
        l_out_ready = 1'b0;
        l_in0_valid = 1'b1; l_in1_valid = 1'b1;
        l_in0_data = 39'h00_0000_0005; l_in1_data = 6'd2;
        @(posedge clk);
        #1;
        l_in0_data = 39'h00_0000_0001; l_in1_data = 6'd1;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if (l_in0_ready !== 1'b0 || l_in1_ready !== 1'b0 ||
                l_out_valid !== 1'b1 || l_out_data !== 39'h00_0000_0014) begin
                errors++;
                $display("FAIL b2b_stall s=%0d: got readies=%b%b valid=%b data=%h, want 00 1 0000000014",
                         s, l_in0_ready, l_in1_ready, l_out_valid, l_out_data);
            end
            @(posedge clk);
            #1;
        end
        l_out_ready = 1'b1;
        #1;
        checks++;
        if (l_in0_ready !== 1'b1 || l_in1_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release_ready: got %b %b, want 1 1", l_in0_ready, l_in1_ready);
        end
        @(posedge clk);
        #1;
        l_in0_valid = 1'b0; l_in1_valid = 1'b0;
        checks++;
        if (l_out_valid !== 1'b1 || l_out_data !== 39'h00_0000_0002) begin
            errors++;
            $display("FAIL b2b_replace: got valid=%b data=%h, want valid=1 data=0000000002",
                     l_out_valid, l_out_data);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_combine_stream(0, 32);
        test_combine_backpressure();
        test_reset_midstream();
        test_filter_drop();
        test_filter_lone_valid();
        test_shift_left();
        test_shift_arith_right();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
